// File: rtl/ram_sync_dp.sv
// Simple dual-port synchronous RAM with byte enables,
// selectable read-during-write and a post-reset clear sequencer.
module ram_sync_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    writeOn,
  input  logic [ADDR_WIDTH-1:0]   wr_address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic                    readOn,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;
  logic                  rd_en;
  logic                  last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    last      = (cnt == ADDR_WIDTH'(DEPTH - 1));
    unique case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = READY;
      end
      READY: begin
        wr_en = writeOn;
        rd_en = readOn;
      end
      default: state_nxt = READY;
    endcase
  end

  assign busy = (state == CLEAR);

  // Write-first forwarding merges the enabled bytes of the
  // in-flight write into the word being read.
  always_comb begin
    rd_word = mem[rd_address];
    if ((RDW_MODE != 0) && wr_en &&
        (wr_address == rd_address)) begin
      for (int k = 0; k < NB; k++) begin
        if (byteEn[k]) rd_word[8*k +: 8] = data_in[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (byteEn[k]) mem[wr_address][8*k +: 8] <= data_in[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) data_out <= rd_word;
    end
  end

endmodule

// File: doc/ram_sync_dp.md
Name: ram_sync_dp

Overview:
Parametrised successor of the single-port synchronous RAM: simple dual-port memory with one write port and one read port usable in the same cycle. Adds per-byte write enables, a selectable read-during-write mode, a read-valid strobe, and a post-reset clear sequencer that zeroes the whole array. Sits as instruction/data storage behind the datapath and is exercised from instruction-file driven benches.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words
RDW_MODE, 0, same-address read during write: 0 = old data (read-first), 1 = new data (write-first)
CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = skip clear, contents undefined

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
writeOn  in  1  write request
wr_address  in  ADDR_WIDTH  write address
data_in  in  DATA_WIDTH  write data
byteEn  in  DATA_WIDTH/8  byte write enables; bit k controls data_in[8k+7:8k]
readOn  in  1  read request
rd_address  in  ADDR_WIDTH  read address
data_out  out  DATA_WIDTH  registered read data
rd_valid  out  1  data_out updated by a read accepted on the previous edge
busy  out  1  clear sequence in progress; all requests ignored

Behaviour:
- Reset (rst_n low, async): data_out = 0, rd_valid = 0, clear counter = 0; state = CLEAR if CLEAR_ON_RESET=1 (busy = 1), else READY (busy = 0). Array contents are not reset asynchronously.
- FSM states: CLEAR, READY.
- CLEAR: each edge writes 0 to word[counter], counter++. On the edge that writes word DEPTH-1 -> READY; busy deasserts after that edge. Clear takes exactly DEPTH edges after reset release.
- In CLEAR: writeOn/readOn ignored; no user write, rd_valid stays 0, data_out holds 0.
- READY write: on an edge with writeOn=1, each byte k with byteEn[k]=1 is stored at wr_address; bytes with byteEn[k]=0 unchanged. writeOn=1 with byteEn=0 changes nothing.
- READY read: on an edge with readOn=1, data_out <= word[rd_address], rd_valid <= 1. Latency one edge: data visible in the cycle after the sampling edge. readOn=0 -> rd_valid <= 0, data_out holds its last value.
- Same-edge read and write to different addresses: independent.
- Same-edge, same-address: RDW_MODE=0 -> data_out = pre-write word; RDW_MODE=1 -> data_out = merged word (enabled bytes from data_in, others old).
- Reset asserted mid-clear or mid-operation: outputs return to reset values immediately; clear restarts from address 0 on release.
- Addresses wrap naturally; no out-of-range addresses exist. Counter is ADDR_WIDTH+1 bits or compares to DEPTH-1; no overflow.
- All inputs sampled only on rising clk; no combinational path input->output.

Test Plan:
- Clear: release rst_n, defaults -> busy high exactly 64 edges, then low; read addresses 0, 31, 63 -> data_out 32'h0, rd_valid 1 one cycle after each.
- Request during clear: writeOn=1, addr 5, data 32'hDEADBEEF at edge 3 of clear -> after clear, read addr 5 returns 32'h0; rd_valid never high while busy.
- Byte enables: write 32'h11223344 byteEn 4'b1111 to addr 10, then 32'hAABBCCDD byteEn 4'b0101 -> read addr 10 returns 32'h11BB33DD; byteEn 4'b0000 write leaves it unchanged.
- Read-during-write: addr 20 holds 32'h00000001; same edge write 32'h00000002 and read addr 20 -> RDW_MODE=0 gives 32'h1, RDW_MODE=1 gives 32'h2; next read gives 32'h2 in both.
- Dual-port concurrency: each cycle write addr i data i*3 while reading addr i-1, i=1..63 -> every read returns (i-1)*3 one cycle later, rd_valid continuous.
- Reset mid-clear: assert rst_n low at clear edge 30 -> data_out 0, rd_valid 0 immediately; after release busy lasts full 64 edges again.
